// File: rtl/ib_lut_pkg.sv
// Shared constants and FSM state type for the IB-LUT write-burst scheduler.
package ib_lut_pkg;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned PAGE_NUM = 15;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned SEL_W    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ib_req_arbiter.sv
// Combinational winner select for the write scheduler.
// IB_WR_SCHED_RR_EN selects round-robin from i_rr_ptr; otherwise lowest index wins.
module ib_req_arbiter #(
  parameter int unsigned NUM_REQ = ib_lut_pkg::NUM_REQ,
  parameter int unsigned SEL_W   = ib_lut_pkg::SEL_W
) (
  input  logic [NUM_REQ-1:0] i_req,
`ifdef IB_WR_SCHED_RR_EN
  input  logic [SEL_W-1:0]   i_rr_ptr,
`endif
  output logic [SEL_W-1:0]   o_win,
  output logic               o_valid
);
  import ib_lut_pkg::*;

`ifdef IB_WR_SCHED_RR_EN
  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = SEL_W'((32'(i_rr_ptr) + i) % NUM_REQ);
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_win   = w_idx;
      end
    end
  end
`else
  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    o_win   = '0;
    o_valid = 1'b0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (i_req[SEL_W'(i - 1)]) begin
        o_valid = 1'b1;
        o_win   = SEL_W'(i - 1);
      end
    end
  end
`endif

endmodule

// File: rtl/ib_lut_wr_sched.sv
// Write-burst scheduler for the four IB-LUT page RAMs: one PAGE_NUM-cycle burst per grant.
// Build option IB_WR_SCHED_RR_EN enables round-robin arbitration (default: fixed priority).
module ib_lut_wr_sched #(
  parameter int unsigned NUM_REQ  = ib_lut_pkg::NUM_REQ,
  parameter int unsigned PAGE_NUM = ib_lut_pkg::PAGE_NUM,
  parameter int unsigned CNT_W    = ib_lut_pkg::CNT_W,
  parameter int unsigned SEL_W    = ib_lut_pkg::SEL_W
) (
  input  logic               ram_clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] done,
  output logic               en,
  output logic [SEL_W-1:0]   ram_sel,
  output logic               busy,
  output logic [CNT_W-1:0]   page_cnt
);
  import ib_lut_pkg::*;

  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PAGE_NUM - 1);

  state_t             r_state;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_done;
  logic               r_en;
  logic [SEL_W-1:0]   r_ram_sel;
  logic               r_busy;
  logic [CNT_W-1:0]   r_page_cnt;

  logic [SEL_W-1:0]   w_win;
  logic               w_valid;

`ifdef IB_WR_SCHED_RR_EN
  logic [SEL_W-1:0]   r_rr_ptr;
  logic [SEL_W-1:0]   w_rr_next;

  assign w_rr_next = (w_win == SEL_W'(NUM_REQ - 1)) ? '0 : w_win + SEL_W'(1);
`endif

  ib_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .SEL_W   (SEL_W)
  ) u_arb (
    .i_req    (req),
`ifdef IB_WR_SCHED_RR_EN
    .i_rr_ptr (r_rr_ptr),
`endif
    .o_win    (w_win),
    .o_valid  (w_valid)
  );

  always_ff @(posedge ram_clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_done     <= '0;
      r_en       <= 1'b0;
      r_ram_sel  <= '0;
      r_busy     <= 1'b0;
      r_page_cnt <= '0;
`ifdef IB_WR_SCHED_RR_EN
      r_rr_ptr   <= '0;
`endif
    end else begin
      r_done <= '0;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state    <= LOAD;
            r_gnt      <= ONE_HOT0 << w_win;
            r_ram_sel  <= w_win;
            r_en       <= 1'b1;
            r_busy     <= 1'b1;
            r_page_cnt <= '0;
`ifdef IB_WR_SCHED_RR_EN
            r_rr_ptr   <= w_rr_next;
`endif
          end
        end
        LOAD: begin
          // The done pulse lands in DRAIN while gnt/ram_sel are still held.
          if (r_page_cnt == CNT_LAST) begin
            r_state <= DRAIN;
            r_en    <= 1'b0;
            r_done  <= r_gnt;
          end else begin
            r_page_cnt <= r_page_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          r_state    <= IDLE;
          r_gnt      <= '0;
          r_busy     <= 1'b0;
          r_page_cnt <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign en       = r_en;
  assign ram_sel  = r_ram_sel;
  assign busy     = r_busy;
  assign page_cnt = r_page_cnt;

endmodule
